// File: rtl/cpu_ctrl_pkg.sv
// Shared CPU control types: program counter width, instruction width and
// the fetched-word payload carried through the fetch queue.
package cpu_ctrl_pkg;

  localparam int unsigned PC_W    = 3;
  localparam int unsigned INSTR_W = 8;

  typedef struct packed {
    logic [INSTR_W-1:0] data;
    logic [PC_W-1:0]    addr;
  } fetch_word_t;

endpackage

// File: rtl/instr_fetch_reader_if.sv
// Fetch request, store write and decode-side handshake bundle for instr_fetch_reader.
interface instr_fetch_reader_if #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 8
);
  logic              pc_valid;
  logic [ADDR_W-1:0] pc_addr;
  logic              pc_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              flush;
  logic              instr_valid;
  logic [DATA_W-1:0] instr_data;
  logic [ADDR_W-1:0] instr_addr;
  logic              instr_ready;

  modport master (
    output pc_valid, pc_addr, wr_en, wr_addr, wr_data, flush, instr_ready,
    input  pc_ready, instr_valid, instr_data, instr_addr
  );

  modport slave (
    input  pc_valid, pc_addr, wr_en, wr_addr, wr_data, flush, instr_ready,
    output pc_ready, instr_valid, instr_data, instr_addr
  );
endinterface

// File: rtl/fetch_queue.sv
// Two-entry synchronous FIFO of fetched words with flush and occupancy count.
module fetch_queue
  import cpu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush,
  input  logic        push,
  input  fetch_word_t push_word,
  input  logic        pop,
  output fetch_word_t head_word,
  output logic [1:0]  count,
  output logic        valid
);

  fetch_word_t q [2];
  logic        head;
  logic        tail;
  logic        do_push;
  logic        do_pop;

  assign do_pop    = pop && (count != 2'd0);
  assign do_push   = push && ((count != 2'd2) || do_pop);
  assign head_word = q[head];
  assign valid     = (count != 2'd0);

  // Flush empties the queue but leaves entry contents untouched.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
      q[0]  <= '0;
      q[1]  <= '0;
    end else if (flush) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (do_push) begin
        q[tail] <= push_word;
        tail    <= ~tail;
      end
      if (do_pop) begin
        head <= ~head;
      end
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch_reader.sv
// Instruction store with a one-cycle read stage feeding a 2-entry output queue;
// requests are credited so no more than two words are ever outstanding.
module instr_fetch_reader
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = PC_W,
  parameter int unsigned DATA_W = INSTR_W
) (
  input  logic                 clk,
  input  logic                 rstn,
  instr_fetch_reader_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              rd_pend;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              accept;
  logic [2:0]        credit_used;
  fetch_word_t       push_word;
  fetch_word_t       head_word;
  logic [1:0]        q_count;
  logic              q_valid;

  // Credit depends only on registered occupancy, never on the handshakes.
  assign credit_used  = 3'(q_count) + 3'(rd_pend);
  assign bus.pc_ready = rstn && !bus.flush && (credit_used < 3'd2);
  assign accept       = bus.pc_valid && bus.pc_ready;

  // Store is not reset and keeps taking writes during flush or reset.
  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Read stage samples the pre-write store contents (read-before-write).
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_pend <= 1'b0;
      rd_addr <= '0;
      rd_data <= '0;
    end else if (bus.flush) begin
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= accept;
      if (accept) begin
        rd_addr <= bus.pc_addr;
        rd_data <= mem[bus.pc_addr];
      end
    end
  end

  always_comb begin
    push_word      = '0;
    push_word.data = INSTR_W'(rd_data);
    push_word.addr = PC_W'(rd_addr);
  end

  fetch_queue u_queue (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (bus.flush),
    .push      (rd_pend),
    .push_word (push_word),
    .pop       (bus.instr_valid && bus.instr_ready),
    .head_word (head_word),
    .count     (q_count),
    .valid     (q_valid)
  );

  assign bus.instr_valid = q_valid;
  assign bus.instr_data  = DATA_W'(head_word.data);
  assign bus.instr_addr  = ADDR_W'(head_word.addr);

endmodule

// File: tb/tb_instr_fetch_reader.sv
// Directed bench for instr_fetch_reader: reset, ordered fetch, backpressure,
// flush, read/write collision and reset with a full queue.
module tb_instr_fetch_reader;
  import cpu_ctrl_pkg::*;

  logic clk;
  logic rstn;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_pop = 0;

  fetch_word_t exp_q [$];
  logic [7:0]  model_mem [8];

  instr_fetch_reader_if ifc ();

  instr_fetch_reader dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: expected words captured at accept, compared on every pop.
  always @(negedge clk) begin
    if (!rstn || ifc.flush) begin
      exp_q.delete();
    end else begin
      if (ifc.instr_valid && ifc.instr_ready) begin
        if (exp_q.size() == 0) begin
          check("pop_unexpected", 32'(1), 32'(0));
        end else begin
          fetch_word_t e;
          e = exp_q.pop_front();
          check("pop_data", 32'(ifc.instr_data), 32'(e.data));
          check("pop_addr", 32'(ifc.instr_addr), 32'(e.addr));
          n_pop++;
        end
      end
      if (ifc.pc_valid && ifc.pc_ready) begin
        exp_q.push_back('{data: model_mem[ifc.pc_addr], addr: ifc.pc_addr});
      end
    end
    if (ifc.wr_en) model_mem[ifc.wr_addr] = ifc.wr_data;
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [2:0] a);
    bit ok = 1'b0;
    ifc.pc_valid = 1'b1;
    ifc.pc_addr  = a;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (ifc.pc_ready) ok = 1'b1;
      sync();
    end
    ifc.pc_valid = 1'b0;
    if (!ok) check("fetch_timeout", 32'(0), 32'(1));
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !ifc.instr_valid) done = 1'b1;
    end
    if (!done) check("drain_timeout", 32'(0), 32'(1));
    sync();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn            = 1'b0;
    ifc.pc_valid    = 1'b0;
    ifc.pc_addr     = '0;
    ifc.wr_en       = 1'b0;
    ifc.wr_addr     = '0;
    ifc.wr_data     = '0;
    ifc.flush       = 1'b0;
    ifc.instr_ready = 1'b0;

    // Reset
    sync();
    sync();
    @(negedge clk);
    check("rst_valid", 32'(ifc.instr_valid), 32'(0));
    check("rst_ready", 32'(ifc.pc_ready), 32'(0));
    check("rst_data", 32'(ifc.instr_data), 32'(0));
    check("rst_addr", 32'(ifc.instr_addr), 32'(0));
    sync();
    rstn = 1'b1;
    @(negedge clk);
    check("rel_ready", 32'(ifc.pc_ready), 32'(1));
    sync();

    // Load store with A0..A7
    for (int i = 0; i < 8; i++) begin
      ifc.wr_en   = 1'b1;
      ifc.wr_addr = 3'(i);
      ifc.wr_data = 8'hA0 + 8'(i);
      sync();
    end
    ifc.wr_en = 1'b0;

    // Sequential fetch with first-word latency
    ifc.instr_ready = 1'b1;
    fetch(3'd0);
    @(negedge clk);
    check("lat_n0_valid", 32'(ifc.instr_valid), 32'(0));
    @(negedge clk);
    check("lat_n1_valid", 32'(ifc.instr_valid), 32'(1));
    check("lat_n1_data", 32'(ifc.instr_data), 32'(8'hA0));
    sync();
    for (int i = 1; i < 8; i++) fetch(3'(i));
    drain();
    check("seq_count", 32'(n_pop), 32'(8));

    // Backpressure: only two outstanding
    ifc.instr_ready = 1'b0;
    fetch(3'd3);
    fetch(3'd4);
    ifc.pc_valid = 1'b1;
    ifc.pc_addr  = 3'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_ready_low", 32'(ifc.pc_ready), 32'(0));
      check("bp_head_data", 32'(ifc.instr_data), 32'(8'hA3));
      check("bp_head_addr", 32'(ifc.instr_addr), 32'(3));
    end
    sync();
    ifc.instr_ready = 1'b1;
    fetch(3'd5);
    drain();
    check("bp_count", 32'(n_pop), 32'(11));

    // Flush with a concurrent request
    ifc.instr_ready = 1'b0;
    fetch(3'd1);
    fetch(3'd2);
    sync();
    ifc.pc_valid = 1'b1;
    ifc.pc_addr  = 3'd6;
    ifc.flush    = 1'b1;
    @(negedge clk);
    check("fl_ready_low", 32'(ifc.pc_ready), 32'(0));
    sync();
    ifc.flush    = 1'b0;
    ifc.pc_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("fl_empty", 32'(ifc.instr_valid), 32'(0));
    end
    check("fl_ready", 32'(ifc.pc_ready), 32'(1));
    sync();
    ifc.instr_ready = 1'b1;
    fetch(3'd7);
    @(negedge clk);
    @(negedge clk);
    check("fl_next_data", 32'(ifc.instr_data), 32'(8'hA7));
    check("fl_next_addr", 32'(ifc.instr_addr), 32'(7));
    drain();

    // Read/write collision returns the old word
    ifc.pc_valid = 1'b1;
    ifc.pc_addr  = 3'd2;
    ifc.wr_en    = 1'b1;
    ifc.wr_addr  = 3'd2;
    ifc.wr_data  = 8'h55;
    @(negedge clk);
    check("col_ready", 32'(ifc.pc_ready), 32'(1));
    sync();
    ifc.pc_valid = 1'b0;
    ifc.wr_en    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("col_old", 32'(ifc.instr_data), 32'(8'hA2));
    drain();
    fetch(3'd2);
    @(negedge clk);
    @(negedge clk);
    check("col_new", 32'(ifc.instr_data), 32'(8'h55));
    drain();

    // Reset while full keeps the store
    ifc.instr_ready = 1'b0;
    fetch(3'd4);
    fetch(3'd5);
    sync();
    @(negedge clk);
    check("full_ready", 32'(ifc.pc_ready), 32'(0));
    check("full_head", 32'(ifc.instr_data), 32'(8'hA4));
    sync();
    rstn = 1'b0;
    sync();
    rstn = 1'b1;
    @(negedge clk);
    check("rfull_valid", 32'(ifc.instr_valid), 32'(0));
    check("rfull_data", 32'(ifc.instr_data), 32'(0));
    check("rfull_ready", 32'(ifc.pc_ready), 32'(1));
    sync();
    ifc.instr_ready = 1'b1;
    fetch(3'd1);
    @(negedge clk);
    @(negedge clk);
    check("rfull_store", 32'(ifc.instr_data), 32'(8'hA1));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
